// File: rtl/hsv_final_stage_pkg.sv
// Shared constants, stage structs and float32 arithmetic helpers for the HSV final stage.
// Float helpers flush denormals to zero and round to nearest-even.
package hsv_final_stage_pkg;

    localparam int          LATENCY   = 3;
    localparam logic [31:0] F_ZERO    = 32'h0000_0000;
    localparam logic [31:0] C_SIXTY   = 32'h4270_0000;
    localparam logic [31:0] F_HUNDRED = 32'h42c8_0000;
    localparam logic [31:0] F_120     = 32'h42f0_0000;
    localparam logic [31:0] F_240     = 32'h4370_0000;
    localparam logic [31:0] F_360     = 32'h43b4_0000;
    localparam logic [31:0] F_QNAN    = 32'h7fc0_0000;

    typedef struct packed {
        logic [31:0] q;
        logic [31:0] s_raw;
        logic [31:0] h_add;
        logic [31:0] t0_v;
        logic        dz;
        logic        mz;
    } s1_t;

    typedef struct packed {
        logic [31:0] h60;
        logic [31:0] s_raw;
        logic [31:0] h_add;
        logic [31:0] t0_v;
        logic        dz;
        logic        mz;
    } s2_t;

    function automatic logic f_nan(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] != 23'h0);
    endfunction

    function automatic logic f_inf(input logic [31:0] x);
        return (x[30:23] == 8'hff) && (x[22:0] == 23'h0);
    endfunction

    function automatic logic f_zero(input logic [31:0] x);
        return x[30:23] == 8'h00;
    endfunction

    // m is 1.xxx with hidden bit at [26], then guard, round and sticky bits.
    function automatic logic [31:0] f_pack(input logic s, input logic signed [11:0] e,
                                           input logic [26:0] m);
        logic        inc;
        logic [24:0] mr;
        logic signed [11:0] ee;
        inc = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[26:3]} + {24'h0, inc};
        ee  = e;
        if (mr[24]) begin
            mr = mr >> 1;
            ee = ee + 12'sd1;
        end
        if (ee >= 12'sd255) return {s, 8'hff, 23'h0};
        if (ee <= 12'sd0)   return {s, 31'h0};
        return {s, ee[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic signed [11:0] e;
        s = a[31] ^ b[31];
        if (f_nan(a) || f_nan(b) || (f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b)))
            return F_QNAN;
        if (f_inf(a) || f_inf(b))   return {s, 8'hff, 23'h0};
        if (f_zero(a) || f_zero(b)) return {s, 31'h0};
        p = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
        e = $signed({4'h0, a[30:23]}) + $signed({4'h0, b[30:23]}) - 12'sd127;
        if (p[47]) return f_pack(s, e + 12'sd1, {p[47:22], |p[21:0]});
        return f_pack(s, e, {p[46:21], |p[20:0]});
    endfunction

    function automatic logic [31:0] f_div(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [49:0]        n, d, q, r;
        logic signed [11:0] e;
        s = a[31] ^ b[31];
        if (f_nan(a) || f_nan(b) || (f_zero(a) && f_zero(b)) || (f_inf(a) && f_inf(b)))
            return F_QNAN;
        if (f_inf(a) || f_zero(b)) return {s, 8'hff, 23'h0};
        if (f_zero(a) || f_inf(b)) return {s, 31'h0};
        n = {1'b1, a[22:0], 26'h0};
        d = {26'h0, 1'b1, b[22:0]};
        q = n / d;
        r = n % d;
        e = $signed({4'h0, a[30:23]}) - $signed({4'h0, b[30:23]}) + 12'sd127;
        if (q[26]) return f_pack(s, e, {q[26:1], q[0] | (r != 50'h0)});
        return f_pack(s, e - 12'sd1, {q[25:0], r != 50'h0});
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [7:0]         dexp;
        logic [50:0]        am, bm, bs, sum, norm;
        logic               st;
        int                 k;
        logic signed [11:0] e;
        if (f_nan(a) || f_nan(b) || (f_inf(a) && f_inf(b) && (a[31] != b[31])))
            return F_QNAN;
        if (f_inf(a))  return a;
        if (f_inf(b))  return b;
        if (f_zero(b)) return a;
        if (f_zero(a)) return b;
        if (b[30:0] > a[30:0]) begin x = b; y = a; end
        else                   begin x = a; y = b; end
        dexp = x[30:23] - y[30:23];
        am   = {2'b01, x[22:0], 26'h0};
        bm   = {2'b01, y[22:0], 26'h0};
        bs   = (dexp > 8'd50) ? 51'h0 : (bm >> dexp);
        st   = (dexp > 8'd50) ? 1'b1 : ((bs << dexp) != bm);
        // Truncated subtrahend bits borrow one LSB; sticky keeps the rounding honest.
        if (x[31] == y[31]) sum = am + bs;
        else                sum = am - bs - {50'h0, st};
        if (sum == 51'h0) return F_ZERO;
        k = 0;
        for (int i = 0; i < 51; i++) if (sum[i]) k = i;
        e    = $signed({4'h0, x[30:23]}) + 12'(k) - 12'sd49;
        norm = sum << (50 - k);
        return f_pack(x[31], e, {norm[50:25], (|norm[24:0]) | st});
    endfunction

endpackage

// File: rtl/hsv_zero_mask.sv
// Final-stage override mux: zero outputs on degenerate pixels and never emit -0.0 hue.
import hsv_final_stage_pkg::*;

module hsv_zero_mask (
    input  logic        dz_i,
    input  logic        mz_i,
    input  logic [31:0] h_sum_i,
    input  logic [31:0] s_raw_i,
    input  logic [31:0] t0_v_i,
    output logic [31:0] h_o,
    output logic [31:0] s_o,
    output logic [31:0] v_o
);

    always_comb begin
        h_o = (dz_i || (h_sum_i[30:0] == 31'h0)) ? F_ZERO : h_sum_i;
        s_o = (dz_i || mz_i) ? F_ZERO : s_raw_i;
        v_o = mz_i ? F_ZERO : t0_v_i;
    end

endmodule

// File: rtl/hsv_final_stage.sv
// Last RGB->HSV stage: hue = 60*t0_h/delta + h_add, sat = delta*t0_s, value = t0_v.
// Three registered stages, II=1, no backpressure.
import hsv_final_stage_pkg::*;

module hsv_final_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [31:0] delta,
    input  logic [31:0] in_max,
    input  logic [31:0] t0_h,
    input  logic [31:0] t0_s,
    input  logic [31:0] t0_v,
    input  logic [31:0] h_add,
    output logic [31:0] h,
    output logic [31:0] s,
    output logic [31:0] v,
    output logic        valid_out
);

    logic [LATENCY-1:0] vld_q;
    s1_t                s1_d, s1_q;
    s2_t                s2_d, s2_q;
    logic [31:0]        h_sum;
    logic [31:0]        h_d, s_d, v_d;
    logic [31:0]        h_q, s_q, v_q;

    // Float units are single-cycle, so their valid_out equals the stage valid feeding them.
    always_comb begin
        s1_d.q     = f_div(t0_h, delta);
        s1_d.s_raw = f_mul(delta, t0_s);
        s1_d.h_add = h_add;
        s1_d.t0_v  = t0_v;
        s1_d.dz    = (delta[30:0] == 31'h0);
        s1_d.mz    = (in_max[30:0] == 31'h0);

        s2_d.h60   = f_mul(C_SIXTY, s1_q.q);
        s2_d.s_raw = s1_q.s_raw;
        s2_d.h_add = s1_q.h_add;
        s2_d.t0_v  = s1_q.t0_v;
        s2_d.dz    = s1_q.dz;
        s2_d.mz    = s1_q.mz;

        h_sum      = f_add(s2_q.h60, s2_q.h_add);
    end

    hsv_zero_mask u_mask (
        .dz_i    (s2_q.dz),
        .mz_i    (s2_q.mz),
        .h_sum_i (h_sum),
        .s_raw_i (s2_q.s_raw),
        .t0_v_i  (s2_q.t0_v),
        .h_o     (h_d),
        .s_o     (s_d),
        .v_o     (v_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_q <= '0;
            s1_q  <= '0;
            s2_q  <= '0;
            h_q   <= '0;
            s_q   <= '0;
            v_q   <= '0;
        end else begin
            vld_q <= {vld_q[LATENCY-2:0], valid_in};
            if (valid_in) s1_q <= s1_d;
            if (vld_q[0]) s2_q <= s2_d;
            if (vld_q[1]) begin
                h_q <= h_d;
                s_q <= s_d;
                v_q <= v_d;
            end
        end
    end

    assign h         = h_q;
    assign s         = s_q;
    assign v         = v_q;
    assign valid_out = vld_q[LATENCY-1];

endmodule

// File: tb/tb_hsv_final_stage.sv
// Directed-vector bench for hsv_final_stage with hand-computed float32 results.
module tb_hsv_final_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] delta = '0, in_max = '0, t0_h = '0, t0_s = '0, t0_v = '0, h_add = '0;
    logic [31:0] h, s, v;
    logic        valid_out;
    int          errors = 0;
    int          checks = 0;

    hsv_final_stage dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .delta     (delta),
        .in_max    (in_max),
        .t0_h      (t0_h),
        .t0_s      (t0_s),
        .t0_v      (t0_v),
        .h_add     (h_add),
        .h         (h),
        .s         (s),
        .v         (v),
        .valid_out (valid_out)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] d, input logic [31:0] m, input logic [31:0] th,
                         input logic [31:0] ts, input logic [31:0] tv, input logic [31:0] ha);
        delta = d; in_max = m; t0_h = th; t0_s = ts; t0_v = tv; h_add = ha;
    endtask

    // One isolated transaction: no early valid, exact latency, one-cycle pulse, hold.
    task automatic single(input string tag,
                          input logic [31:0] d, input logic [31:0] m, input logic [31:0] th,
                          input logic [31:0] ts, input logic [31:0] tv, input logic [31:0] ha,
                          input logic [31:0] eh, input logic [31:0] es, input logic [31:0] ev);
        drive(d, m, th, ts, tv, ha);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        drive(32'h3f80_0000, 32'h3f80_0000, 32'h3f00_0000, 32'h42c8_0000, 32'h4000_0000, 32'h4370_0000);
        tick();
        chk({tag, ".early"}, {31'h0, valid_out}, 32'h0);
        tick();
        chk({tag, ".vld"}, {31'h0, valid_out}, 32'h1);
        chk({tag, ".h"}, h, eh);
        chk({tag, ".s"}, s, es);
        chk({tag, ".v"}, v, ev);
        tick();
        chk({tag, ".pulse"}, {31'h0, valid_out}, 32'h0);
        chk({tag, ".hold_h"}, h, eh);
    endtask

    logic [31:0] bd [4], bth [4], bts [4], bha [4], beh [4];

    initial begin
        tick();
        tick();
        chk("rst.vld", {31'h0, valid_out}, 32'h0);
        chk("rst.h", h, 32'h0);
        chk("rst.s", s, 32'h0);
        chk("rst.v", v, 32'h0);
        rst = 1'b1;

        single("red", 32'h3f800000, 32'h3f800000, 32'h0, 32'h42c80000, 32'h42c80000, 32'h0,
               32'h0, 32'h42c80000, 32'h42c80000);
        single("green", 32'h3f800000, 32'h3f800000, 32'h0, 32'h42c80000, 32'h42c80000, 32'h42f00000,
               32'h42f00000, 32'h42c80000, 32'h42c80000);
        single("magenta", 32'h3f800000, 32'h3f800000, 32'hbf000000, 32'h42c80000, 32'h42c80000, 32'h43b40000,
               32'h43a50000, 32'h42c80000, 32'h42c80000);
        // 0.25/0.5 = 0.5 -> 30 + 240 = 270; s = 0.5*200 = 100
        single("div", 32'h3f000000, 32'h3f800000, 32'h3e800000, 32'h43480000, 32'h42c80000, 32'h43700000,
               32'h43870000, 32'h42c80000, 32'h42c80000);
        single("gray", 32'h0, 32'h3f000000, 32'h0, 32'h43480000, 32'h42480000, 32'h0,
               32'h0, 32'h0, 32'h42480000);
        single("black", 32'h0, 32'h0, 32'h0, 32'h7f800000, 32'h0, 32'h0,
               32'h0, 32'h0, 32'h0);
        single("black_vmask", 32'h0, 32'h80000000, 32'h0, 32'h7f800000, 32'h7fc00000, 32'h0,
               32'h0, 32'h0, 32'h0);
        // -0/1 gives a -0.0 hue sum, which must come out as +0.0
        single("negzero", 32'h3f800000, 32'h3f800000, 32'h80000000, 32'h42c80000, 32'h42c80000, 32'h0,
               32'h0, 32'h42c80000, 32'h42c80000);

        bd  = '{32'h3f800000, 32'h3f800000, 32'h3f800000, 32'h3f000000};
        bth = '{32'h0,        32'h0,        32'hbf000000, 32'h3e800000};
        bts = '{32'h42c80000, 32'h42c80000, 32'h42c80000, 32'h43480000};
        bha = '{32'h0,        32'h42f00000, 32'h43b40000, 32'h43700000};
        beh = '{32'h0,        32'h42f00000, 32'h43a50000, 32'h43870000};
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                drive(bd[i], 32'h3f800000, bth[i], bts[i], 32'h42c80000, bha[i]);
                valid_in = 1'b1;
            end else begin
                valid_in = 1'b0;
            end
            tick();
            if (i >= 2 && i < 6) begin
                chk($sformatf("b2b%0d.vld", i - 2), {31'h0, valid_out}, 32'h1);
                chk($sformatf("b2b%0d.h", i - 2), h, beh[i - 2]);
                chk($sformatf("b2b%0d.s", i - 2), s, 32'h42c80000);
            end
        end
        chk("b2b.end", {31'h0, valid_out}, 32'h0);

        drive(32'h3f800000, 32'h3f800000, 32'h0, 32'h42c80000, 32'h42c80000, 32'h42f00000);
        valid_in = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        valid_in = 1'b0;
        chk("mrst.vld", {31'h0, valid_out}, 32'h0);
        chk("mrst.h", h, 32'h0);
        chk("mrst.s", s, 32'h0);
        chk("mrst.v", v, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mrst.drop%0d", i), {31'h0, valid_out}, 32'h0);
        end
        chk("mrst.hold_v", v, 32'h0);

        single("recover", 32'h3f800000, 32'h3f800000, 32'h0, 32'h42c80000, 32'h42c80000, 32'h42f00000,
               32'h42f00000, 32'h42c80000, 32'h42c80000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
